dport_axi_lite: RTL and testbench

//  Bridges the external side of the data-port mux to an AXI4-Lite master for uncached peripheral/DDR-ctrl access.

---
 rtl/dport_axi_lite_if.sv | 36 +++
 rtl/dport_axi_lite.sv | 258 +++++++++++++++++++++++++
 tb/tb_dport_axi_lite.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dport_axi_lite_if.sv
// AXI4-Lite channel bundle between the dport bridge (master) and the
// interconnect / peripheral side (slave). 32-bit address and data.
interface dport_axi_lite_if;
  // Write address channel
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  // Write data channel
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wready;
  // Write response channel
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  // Read address channel
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  // Read data channel
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/dport_axi_lite.sv
// dport_axi_lite: bridges the external data-port mux side to an AXI4-Lite
// master for uncached peripheral / DDR-controller access.
//  - rd -> AR, wr -> AW+W, CMOs complete locally with no bus traffic.
//  - In-flight requests tracked in a tag FIFO (OUTSTANDING deep); read and
//    write traffic never mix in flight, so responses come back in order.
//  - Optional macro DPORT_AXI_ERR_EN: report non-OKAY rresp/bresp on
//    mem_error_o. Without it mem_error_o is tied low.
module dport_axi_lite #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned TAG_W       = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_wr_i,
  input  logic             mem_rd_i,
  input  logic [3:0]       mem_wr_i,
  input  logic             mem_cacheable_i,
  input  logic [TAG_W-1:0] mem_req_tag_i,
  input  logic             mem_invalidate_i,
  input  logic             mem_writeback_i,
  input  logic             mem_flush_i,
  output logic [31:0]      mem_data_rd_o,
  output logic             mem_accept_o,
  output logic             mem_ack_o,
  output logic             mem_error_o,
  output logic [TAG_W-1:0] mem_resp_tag_o,
  dport_axi_lite_if.master axi
);

  typedef enum logic [1:0] {
    KIND_IDLE = 2'd0,
    KIND_RD   = 2'd1,
    KIND_WR   = 2'd2,
    KIND_CMO  = 2'd3
  } kind_e;

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  // Tag FIFO storage
  logic [TAG_W-1:0] tag_fifo_q  [OUTSTANDING];
  kind_e            kind_fifo_q [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Kind of traffic currently in flight
  kind_e kind_q;
  kind_e kind_d;

  // AXI request channel state
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic        awvalid_q;
  logic [31:0] awaddr_q;
  logic        wvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // Response registers towards the mux
  logic             ack_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic [31:0]      rdata_q;

  // Combinational control
  kind_e            req_kind;
  logic             fifo_empty;
  logic             fifo_full;
  logic             slot_free;
  logic             accept;
  kind_e            head_kind;
  logic [TAG_W-1:0] head_tag;
  logic             rready;
  logic             bready;
  logic             r_hs;
  logic             b_hs;
  logic             cmo_pop;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Decode incoming request: wr beats rd beats CMO
  always_comb begin
    req_kind = KIND_IDLE;
    if (mem_wr_i != '0) begin
      req_kind = KIND_WR;
    end else if (mem_rd_i) begin
      req_kind = KIND_RD;
    end else if (mem_invalidate_i || mem_writeback_i || mem_flush_i) begin
      req_kind = KIND_CMO;
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign slot_free  = !(arvalid_q || awvalid_q || wvalid_q);

  // Accept decision; a pop in the same cycle never frees a full FIFO early
  always_comb begin
    accept = 1'b0;
    case (req_kind)
      KIND_RD, KIND_WR: accept = !fifo_full && slot_free &&
                                 (fifo_empty || (req_kind == kind_q));
      KIND_CMO:         accept = fifo_empty && slot_free;
      default:          accept = 1'b0;
    endcase
  end

  assign head_kind = kind_fifo_q[rd_ptr_q];
  assign head_tag  = tag_fifo_q[rd_ptr_q];

  // Only the channel matching the oldest request is ever ready; a stray
  // response stalls on the bus instead of being dropped.
  assign rready  = !fifo_empty && (head_kind == KIND_RD);
  assign bready  = !fifo_empty && (head_kind == KIND_WR);
  assign r_hs    = rready && axi.rvalid;
  assign b_hs    = bready && axi.bvalid;
  assign cmo_pop = !fifo_empty && (head_kind == KIND_CMO);
  assign pop     = r_hs || b_hs || cmo_pop;

  // Traffic-kind register: follows the last accepted request
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      kind_q <= KIND_IDLE;
    end else begin
      kind_q <= kind_d;
    end
  end

  // Traffic-kind next state; equal kinds are guaranteed while non-empty
  always_comb begin
    kind_d = kind_q;
    if (accept) begin
      kind_d = req_kind;
    end
  end

  // Tag FIFO: push on accept, pop on response handshake or CMO at head
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        tag_fifo_q[i]  <= '0;
        kind_fifo_q[i] <= KIND_IDLE;
      end
    end else begin
      if (accept) begin
        tag_fifo_q[wr_ptr_q]  <= mem_req_tag_i;
        kind_fifo_q[wr_ptr_q] <= req_kind;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (accept && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!accept && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // AXI request channels: each valid is held with its payload until ready
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (arvalid_q && axi.arready) begin
        arvalid_q <= 1'b0;
      end else if (accept && (req_kind == KIND_RD)) begin
        arvalid_q <= 1'b1;
        araddr_q  <= mem_addr_i;
      end

      if (awvalid_q && axi.awready) begin
        awvalid_q <= 1'b0;
      end else if (accept && (req_kind == KIND_WR)) begin
        awvalid_q <= 1'b1;
        awaddr_q  <= mem_addr_i;
      end

      if (wvalid_q && axi.wready) begin
        wvalid_q <= 1'b0;
      end else if (accept && (req_kind == KIND_WR)) begin
        wvalid_q <= 1'b1;
        wdata_q  <= mem_data_wr_i;
        wstrb_q  <= mem_wr_i;
      end
    end
  end

  // Response path: ack one cycle after the pop, with the head tag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q      <= 1'b0;
      resp_tag_q <= '0;
      rdata_q    <= '0;
    end else begin
      ack_q <= pop;
      if (pop) begin
        resp_tag_q <= head_tag;
        rdata_q    <= r_hs ? axi.rdata : '0;
      end
    end
  end

`ifdef DPORT_AXI_ERR_EN
  logic err_q;

  // Error flag registered alongside the ack it belongs to
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (r_hs && (axi.rresp != 2'b00)) || (b_hs && (axi.bresp != 2'b00));
    end
  end

  assign mem_error_o = err_q;

  logic unused_inputs;
  assign unused_inputs = mem_cacheable_i;
`else
  assign mem_error_o = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{mem_cacheable_i, axi.rresp, axi.bresp};
`endif

  assign mem_accept_o   = accept;
  assign mem_ack_o      = ack_q;
  assign mem_resp_tag_o = resp_tag_q;
  assign mem_data_rd_o  = rdata_q;

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.rready  = rready;
  assign axi.bready  = bready;

endmodule

// File: tb/tb_dport_axi_lite.sv
// Directed bench for dport_axi_lite with a response scoreboard.
module tb_dport_axi_lite;
  localparam int unsigned TAG_W = 11;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_CMO = 2;
`ifdef DPORT_AXI_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [31:0]      mem_addr_i;
  logic [31:0]      mem_data_wr_i;
  logic             mem_rd_i;
  logic [3:0]       mem_wr_i;
  logic             mem_cacheable_i;
  logic [TAG_W-1:0] mem_req_tag_i;
  logic             mem_invalidate_i;
  logic             mem_writeback_i;
  logic             mem_flush_i;
  logic [31:0]      mem_data_rd_o;
  logic             mem_accept_o;
  logic             mem_ack_o;
  logic             mem_error_o;
  logic [TAG_W-1:0] mem_resp_tag_o;

  dport_axi_lite_if axi();

  always #5 clk_i = ~clk_i;

  dport_axi_lite #(.OUTSTANDING(2), .TAG_W(TAG_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mem_addr_i       (mem_addr_i),
    .mem_data_wr_i    (mem_data_wr_i),
    .mem_rd_i         (mem_rd_i),
    .mem_wr_i         (mem_wr_i),
    .mem_cacheable_i  (mem_cacheable_i),
    .mem_req_tag_i    (mem_req_tag_i),
    .mem_invalidate_i (mem_invalidate_i),
    .mem_writeback_i  (mem_writeback_i),
    .mem_flush_i      (mem_flush_i),
    .mem_data_rd_o    (mem_data_rd_o),
    .mem_accept_o     (mem_accept_o),
    .mem_ack_o        (mem_ack_o),
    .mem_error_o      (mem_error_o),
    .mem_resp_tag_o   (mem_resp_tag_o),
    .axi              (axi)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded); record expected ack
  task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                       input logic exp_err);
    int n = 0;
    mem_addr_i    = addr;
    mem_data_wr_i = wdata;
    mem_req_tag_i = tag;
    mem_rd_i      = (kind == K_RD);
    mem_wr_i      = (kind == K_WR) ? 4'hF : 4'h0;
    mem_flush_i   = (kind == K_CMO);
    @(negedge clk_i);
    while (!mem_accept_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("accept", {63'd0, mem_accept_o}, 64'd1);
    if (mem_accept_o) sb.push_back({tag, exp_data, exp_err});
    tick();
    mem_rd_i    = 1'b0;
    mem_wr_i    = 4'h0;
    mem_flush_i = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    axi.rdata  = data;
    axi.rresp  = resp;
    axi.rvalid = 1'b1;
    @(negedge clk_i);
    while (!axi.rready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("rready", {63'd0, axi.rready}, 64'd1);
    tick();
    axi.rvalid = 1'b0;
  endtask

  task automatic b_beat(input logic [1:0] resp);
    int n = 0;
    axi.bresp  = resp;
    axi.bvalid = 1'b1;
    @(negedge clk_i);
    while (!axi.bready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("bready", {63'd0, axi.bready}, 64'd1);
    tick();
    axi.bvalid = 1'b0;
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rst_i && mem_ack_o) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL ack_unexpected observed=tag %0h expected=no ack", mem_resp_tag_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_tag", {53'd0, mem_resp_tag_o}, {53'd0, e.tag});
        chk("ack_data", {32'd0, mem_data_rd_o}, {32'd0, e.data});
        chk("ack_err", {63'd0, mem_error_o}, {63'd0, e.err});
      end
    end
  end

  initial begin
    mem_addr_i = '0; mem_data_wr_i = '0; mem_rd_i = 1'b0; mem_wr_i = '0;
    mem_cacheable_i = 1'b0; mem_req_tag_i = '0;
    mem_invalidate_i = 1'b0; mem_writeback_i = 1'b0; mem_flush_i = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;

    // Reset state
    @(negedge clk_i);
    chk("rst_ctrl", {56'd0, mem_accept_o, mem_ack_o, mem_error_o, axi.arvalid,
                     axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 64'd0);
    chk("rst_resp", {21'd0, mem_resp_tag_o, mem_data_rd_o}, 64'd0);
    chk("rst_addr", {axi.araddr, axi.awaddr}, 64'd0);
    tick();
    rst_i = 1'b1;

    // 1: single read, R two cycles after AR
    axi.arready = 1'b1;
    issue(K_RD, 32'h9000_0010, '0, 11'h005, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk_i);
    chk("t1_ar", {31'd0, axi.arvalid, axi.araddr}, {31'd0, 1'b1, 32'h9000_0010});
    tick();
    @(negedge clk_i);
    chk("t1_ar_drop", {63'd0, axi.arvalid}, 64'd0);
    tick();
    r_beat(32'hDEAD_BEEF, 2'b00);
    @(negedge clk_i);
    chk("t1_ack", {63'd0, mem_ack_o}, 64'd1);
    tick();
    @(negedge clk_i);
    chk("t1_ack_pulse", {63'd0, mem_ack_o}, 64'd0);
    tick();

    // 2: write, AW accepted one cycle before W; new write blocked while W pends
    issue(K_WR, 32'h9000_0000, 32'h0000_1234, 11'h006, 32'h0, 1'b0);
    axi.awready = 1'b1;
    @(negedge clk_i);
    chk("t2_aw_w", {26'd0, axi.awvalid, axi.wvalid, axi.wstrb, axi.awaddr},
        {26'd0, 1'b1, 1'b1, 4'hF, 32'h9000_0000});
    chk("t2_wdata", {32'd0, axi.wdata}, {32'd0, 32'h0000_1234});
    tick();
    axi.awready = 1'b0;
    axi.wready  = 1'b1;
    mem_wr_i = 4'hF;
    mem_req_tag_i = 11'h007;
    @(negedge clk_i);
    chk("t2_w_pending", {62'd0, axi.awvalid, axi.wvalid}, 64'd1);
    chk("t2_no_accept_w_pend", {63'd0, mem_accept_o}, 64'd0);
    tick();
    axi.wready = 1'b0;
    mem_wr_i = 4'h0;
    @(negedge clk_i);
    chk("t2_w_done", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'd1);
    tick();
    b_beat(2'b00);
    @(negedge clk_i);
    chk("t2_ack", {63'd0, mem_ack_o}, 64'd1);
    tick();

    // 3: two reads in flight, third blocked until the first R returns
    axi.arready = 1'b1;
    issue(K_RD, 32'h9000_0100, '0, 11'h010, 32'hA1A1_0001, 1'b0);
    issue(K_RD, 32'h9000_0104, '0, 11'h011, 32'hA1A1_0002, 1'b0);
    mem_rd_i = 1'b1;
    mem_addr_i = 32'h9000_0108;
    mem_req_tag_i = 11'h012;
    @(negedge clk_i);
    chk("t3_blocked_ar", {63'd0, mem_accept_o}, 64'd0);
    tick();
    @(negedge clk_i);
    chk("t3_blocked_full", {63'd0, mem_accept_o}, 64'd0);
    tick();
    axi.rdata  = 32'hA1A1_0001;
    axi.rresp  = 2'b00;
    axi.rvalid = 1'b1;
    @(negedge clk_i);
    chk("t3_rready", {63'd0, axi.rready}, 64'd1);
    chk("t3_full_pop_no_bypass", {63'd0, mem_accept_o}, 64'd0);
    tick();
    axi.rvalid = 1'b0;
    issue(K_RD, 32'h9000_0108, '0, 11'h012, 32'hA1A1_0003, 1'b0);
    r_beat(32'hA1A1_0002, 2'b00);
    r_beat(32'hA1A1_0003, 2'b00);
    tick();
    @(negedge clk_i);
    chk("t3_drained", sb.size(), 64'd0);
    tick();

    // 4/5: write held off behind an in-flight read, then B with SLVERR
    issue(K_RD, 32'h9000_0200, '0, 11'h020, 32'h5555_AAAA, 1'b0);
    mem_wr_i = 4'hF;
    mem_addr_i = 32'h9000_0204;
    mem_data_wr_i = 32'hCAFE_F00D;
    mem_req_tag_i = 11'h021;
    @(negedge clk_i);
    chk("t4_wr_blocked_ar", {63'd0, mem_accept_o}, 64'd0);
    tick();
    @(negedge clk_i);
    chk("t4_wr_blocked_kind", {63'd0, mem_accept_o}, 64'd0);
    tick();
    r_beat(32'h5555_AAAA, 2'b00);
    issue(K_WR, 32'h9000_0204, 32'hCAFE_F00D, 11'h021, 32'h0, ERR_EN);
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    @(negedge clk_i);
    chk("t4_aw_w", {30'd0, axi.awvalid, axi.wvalid, axi.awaddr},
        {30'd0, 1'b1, 1'b1, 32'h9000_0204});
    tick();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    b_beat(2'b10);
    @(negedge clk_i);
    chk("t5_ack_err", {62'd0, mem_ack_o, mem_error_o}, {62'd0, 1'b1, ERR_EN});
    tick();

    // 6: flush with empty FIFO completes locally, ack two cycles after request
    axi.arready = 1'b0;
    issue(K_CMO, 32'h0, 32'h0, 11'h030, 32'h0, 1'b0);
    @(negedge clk_i);
    chk("t6_no_axi", {60'd0, axi.arvalid, axi.awvalid, axi.wvalid, mem_ack_o}, 64'd0);
    tick();
    @(negedge clk_i);
    chk("t6_cmo_ack", {63'd0, mem_ack_o}, 64'd1);
    tick();

    // CMO blocked behind a stalled read, then reset lands mid-AR
    issue(K_RD, 32'h9000_0300, '0, 11'h040, 32'h0, 1'b0);
    mem_flush_i = 1'b1;
    @(negedge clk_i);
    chk("t6_cmo_blocked", {63'd0, mem_accept_o}, 64'd0);
    chk("t6_ar_stalled", {63'd0, axi.arvalid}, 64'd1);
    mem_flush_i = 1'b0;
    #1;
    rst_i = 1'b0;
    #1;
    chk("t6_rst_ctrl", {59'd0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready,
                        mem_accept_o}, 64'd0);
    chk("t6_rst_resp", {21'd0, mem_resp_tag_o, mem_data_rd_o}, 64'd0);
    sb.delete();
    tick();
    rst_i = 1'b1;

    // Stray responses after reset must be stalled, not acked
    axi.rdata  = 32'h0BAD_0BAD;
    axi.rvalid = 1'b1;
    axi.bvalid = 1'b1;
    @(negedge clk_i);
    chk("t6_stray_ready", {62'd0, axi.rready, axi.bready}, 64'd0);
    tick();
    @(negedge clk_i);
    chk("t6_no_spurious_ack", {63'd0, mem_ack_o}, 64'd0);
    axi.rvalid = 1'b0;
    axi.bvalid = 1'b0;
    tick();
    chk("sb_empty", sb.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
